// File: rtl/index_buffer.sv
// Lowest-free-slot tag allocator with per-slot metadata storage.
// Define INDEX_BUFFER_ASSERT_EN to compile in simulation-only misuse checks.
module index_buffer #(
  parameter int DATAW = 1,
  parameter int SIZE  = 4,
  localparam int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ADDRW-1:0] write_addr,
  input  logic             acquire_slot,
  input  logic [DATAW-1:0] write_data,
  input  logic [ADDRW-1:0] read_addr,
  output logic [DATAW-1:0] read_data,
  input  logic [ADDRW-1:0] release_addr,
  input  logic             release_slot,
  output logic             full,
  output logic             empty
);

  logic [SIZE-1:0]  r_free;
  logic [DATAW-1:0] r_mem [SIZE];

  logic [SIZE-1:0]  w_free_nxt;
  logic [ADDRW-1:0] w_wa;
  logic             w_full;
  logic             w_acq;
  logic             w_rel_in_range;
  logic             w_rel;
  logic             w_rd_in_range;

  assign w_full = ~|r_free;
  assign full   = w_full;
  assign empty  = &r_free;

  // Scan high to low so the lowest free index is the last one kept.
  always_comb begin
    w_wa = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (r_free[i]) w_wa = ADDRW'(i);
    end
  end

  assign write_addr = w_wa;

  assign w_acq = acquire_slot & ~w_full;

  assign w_rel_in_range =
    ({{(32-ADDRW){1'b0}}, release_addr} < 32'(SIZE));
  assign w_rel = release_slot & w_rel_in_range;

  // Acquire is applied after release so it wins on the same slot.
  always_comb begin
    w_free_nxt = r_free;
    if (w_rel) w_free_nxt[release_addr] = 1'b1;
    if (w_acq) w_free_nxt[w_wa] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_free <= '1;
    end else begin
      r_free <= w_free_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_acq) begin
      r_mem[w_wa] <= write_data;
    end
  end

  assign w_rd_in_range =
    ({{(32-ADDRW){1'b0}}, read_addr} < 32'(SIZE));

  always_comb begin
    read_data = '0;
    if (w_rd_in_range) read_data = r_mem[read_addr];
  end

`ifdef INDEX_BUFFER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (acquire_slot && w_full)
        $error("index_buffer @%0t: acquire while full (idx %0d)",
               $time, w_wa);
      if (release_slot && !w_rel_in_range)
        $error("index_buffer @%0t: release out of range (idx %0d)",
               $time, release_addr);
      else if (release_slot && r_free[release_addr])
        $error("index_buffer @%0t: release of free slot (idx %0d)",
               $time, release_addr);
    end
  end
`endif

endmodule

// File: tb/tb_index_buffer.sv
// Directed-vector bench for index_buffer (SIZE=4, DATAW=8).
// Outputs are compared mid-cycle, before the edge that applies each vector.
module tb_index_buffer;

  localparam int DATAW = 8;
  localparam int SIZE  = 4;
  localparam int ADDRW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [ADDRW-1:0] write_addr;
  logic             acquire_slot;
  logic [DATAW-1:0] write_data;
  logic [ADDRW-1:0] read_addr;
  logic [DATAW-1:0] read_data;
  logic [ADDRW-1:0] release_addr;
  logic             release_slot;
  logic             full;
  logic             empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  index_buffer #(.DATAW(DATAW), .SIZE(SIZE)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_addr   (write_addr),
    .acquire_slot (acquire_slot),
    .write_data   (write_data),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .release_addr (release_addr),
    .release_slot (release_slot),
    .full         (full),
    .empty        (empty)
  );

  typedef struct {
    logic             acq;
    logic [DATAW-1:0] wdata;
    logic             rel;
    logic [ADDRW-1:0] raddr_rel;
    logic [ADDRW-1:0] rd;
    logic [ADDRW-1:0] exp_wa;
    logic             exp_full;
    logic             exp_empty;
    logic             chk_rd;
    logic [DATAW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic add(input logic acq, input logic [7:0] wd,
                     input logic rel, input logic [1:0] ra,
                     input logic [1:0] rd, input logic [1:0] wa,
                     input logic f, input logic e,
                     input logic crd, input logic [7:0] erd);
    vec_t v;
    v.acq = acq; v.wdata = wd; v.rel = rel; v.raddr_rel = ra;
    v.rd = rd; v.exp_wa = wa; v.exp_full = f; v.exp_empty = e;
    v.chk_rd = crd; v.exp_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic acq,
                       input logic [7:0] wd, input logic rel,
                       input logic [1:0] ra, input logic [1:0] rd);
    reset = rst; acquire_slot = acq; write_data = wd;
    release_slot = rel; release_addr = ra; read_addr = rd;
  endtask

  task automatic status(input string tag, input logic [1:0] wa,
                        input logic f, input logic e);
    chk({tag, ".write_addr"}, 32'(write_addr), 32'(wa));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    //  acq wd     rel ra  rd  wa  f  e  crd erd
    add(0, 8'h00,  0, 0,   0,  0,  0, 1, 0, 8'h00); // idle after reset
    add(1, 8'hA0,  0, 0,   0,  0,  0, 1, 0, 8'h00);
    add(1, 8'hA1,  0, 0,   0,  1,  0, 0, 0, 8'h00);
    add(1, 8'hA2,  0, 0,   0,  2,  0, 0, 0, 8'h00);
    add(1, 8'hA3,  0, 0,   0,  3,  0, 0, 0, 8'h00);
    add(0, 8'h00,  0, 0,   2,  0,  1, 0, 1, 8'hA2);
    add(1, 8'hFF,  0, 0,   0,  0,  1, 0, 1, 8'hA0); // acquire while full
    add(0, 8'h00,  0, 0,   3,  0,  1, 0, 1, 8'hA3);
    add(0, 8'h00,  1, 1,   1,  0,  1, 0, 1, 8'hA1); // release 1
    add(0, 8'h00,  0, 0,   1,  1,  0, 0, 1, 8'hA1);
    add(1, 8'hB1,  0, 0,   0,  1,  0, 0, 1, 8'hA0);
    add(0, 8'h00,  0, 0,   1,  0,  1, 0, 1, 8'hB1);
    add(0, 8'h00,  1, 0,   2,  0,  1, 0, 1, 8'hA2); // free 0
    add(0, 8'h00,  1, 2,   0,  0,  0, 0, 1, 8'hA0); // free 2
    add(1, 8'hC0,  1, 3,   0,  0,  0, 0, 1, 8'hA0); // acq 0 + rel 3
    add(0, 8'h00,  0, 0,   0,  2,  0, 0, 1, 8'hC0);
    add(0, 8'h00,  1, 3,   3,  2,  0, 0, 1, 8'hA3); // rel free slot
    add(1, 8'hD2,  1, 2,   0,  2,  0, 0, 1, 8'hC0); // acq wins on 2
    add(0, 8'h00,  0, 0,   2,  3,  0, 0, 1, 8'hD2);
    add(1, 8'hE3,  0, 0,   0,  3,  0, 0, 1, 8'hC0);
    add(1, 8'h55,  1, 0,   3,  0,  1, 0, 1, 8'hE3); // full: acq+rel
    add(0, 8'h00,  0, 0,   0,  0,  0, 0, 1, 8'hC0);
    add(1, 8'h60,  0, 0,   0,  0,  0, 0, 1, 8'hC0);
    add(0, 8'h00,  0, 0,   0,  0,  1, 0, 1, 8'h60);

    drive(1, 0, 8'h00, 1, 2, 0);
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(0, vecs[k].acq, vecs[k].wdata, vecs[k].rel,
            vecs[k].raddr_rel, vecs[k].rd);
      #1;
      status($sformatf("v%0d", k), vecs[k].exp_wa,
             vecs[k].exp_full, vecs[k].exp_empty);
      if (vecs[k].chk_rd)
        chk($sformatf("v%0d.read_data", k), 32'(read_data),
            32'(vecs[k].exp_rd));
    end

    // Reset mid-operation: two slots held, reset with acquire+release.
    @(negedge clk); drive(1, 0, 8'h00, 0, 0, 0);
    @(negedge clk); drive(0, 1, 8'h11, 0, 0, 0);
    #1; status("rst0", 0, 0, 1);
    @(negedge clk); drive(0, 1, 8'h22, 0, 0, 0);
    #1; status("rst1", 1, 0, 0);
    @(negedge clk); drive(1, 1, 8'h33, 1, 0, 0);
    #1; status("rst2", 2, 0, 0);
    @(negedge clk); drive(0, 0, 8'h00, 0, 0, 0);
    #1; status("rst3", 0, 0, 1);
    @(negedge clk); drive(0, 1, 8'h44, 0, 0, 0);
    @(negedge clk); drive(0, 0, 8'h00, 0, 0, 0);
    #1; status("rst4", 1, 0, 0);
    chk("rst4.read_data", 32'(read_data), 32'h44);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
